// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: direct-mapped, one-word-per-line instruction cache that
// sits between the instruction fetcher and the memory controller's icache port.
// Hits return in one cycle; misses issue a held word read and fill on return.
// Optional feature macro: ICACHE_STAT_EN adds hit/miss/stall counters.
module icache_fetch_unit #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        fetch_valid_in,
  input  logic        flush_in,
  output logic        ready_out,
  output logic [31:0] inst_out,
  output logic        inst_valid_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic        mem_r_nw_out,
  output logic [2:0]  mem_type_out,
  output logic        mem_activate_out,
  input  logic [31:0] mem_data_in,
  input  logic        mem_available_in,
  input  logic [1:0]  mem_task_src_in,
  input  logic        icache_block_in
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out,
  output logic [31:0] stall_cnt_out
`endif
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_BITS  = 32 - INDEX_BITS - 2;
  localparam logic [1:0] SRC_ICACHE = 2'b10;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, state_next;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [31:0] req_addr;
  logic        discard;

  logic [INDEX_BITS-1:0] pc_idx, req_idx;
  logic [TAG_BITS-1:0]   pc_tag, req_tag;
  logic                  lookup_hit;
  logic                  hit_acc, miss_acc, resp;

  // Byte offset of the fetch address is not used by a word cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_in[1:0];

  assign pc_idx  = pc_in[INDEX_BITS+1:2];
  assign pc_tag  = pc_in[31:INDEX_BITS+2];
  assign req_idx = req_addr[INDEX_BITS+1:2];
  assign req_tag = req_addr[31:INDEX_BITS+2];

  assign lookup_hit = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  assign ready_out    = (state == IDLE);
  assign mem_data_out = 32'h0;
  assign mem_r_nw_out = 1'b1;
  assign mem_type_out = 3'b000;

  // State register; rdy_in low freezes the FSM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_next;
  end

  // Next-state decode: classify accepted requests and recognise responses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next = state;
    hit_acc    = 1'b0;
    miss_acc   = 1'b0;
    resp       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_valid_in && !flush_in) begin
          if (lookup_hit) begin
            hit_acc = 1'b1;
          end else begin
            miss_acc   = 1'b1;
            state_next = MISS;
          end
        end
      end
      MISS: begin
        resp = mem_available_in && (mem_task_src_in == SRC_ICACHE);
        if (resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output, request and discard registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_out         <= 32'h0;
      inst_valid_out   <= 1'b0;
      mem_activate_out <= 1'b0;
      mem_addr_out     <= 32'h0;
      req_addr         <= 32'h0;
      discard          <= 1'b0;
    end else if (rdy_in) begin
      inst_valid_out <= 1'b0;
      if (hit_acc) begin
        inst_out       <= data_mem[pc_idx];
        inst_valid_out <= 1'b1;
      end
      if (miss_acc) begin
        req_addr         <= {pc_in[31:2], 2'b00};
        mem_addr_out     <= {pc_in[31:2], 2'b00};
        mem_activate_out <= 1'b1;
        discard          <= 1'b0;
      end
      if (state == MISS) begin
        if (resp) begin
          mem_activate_out <= 1'b0;
          mem_addr_out     <= 32'h0;
          discard          <= 1'b0;
          // A flush in the response cycle discards just like an earlier one.
          if (!(discard || flush_in)) begin
            inst_out       <= mem_data_in;
            inst_valid_out <= 1'b1;
          end
        end else if (flush_in) begin
          // Request stays up: the controller may already have latched it.
          discard <= 1'b1;
        end
      end
    end
  end

  // Valid bits are the only part of the array state that needs reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)              valid          <= '0;
    else if (rdy_in && resp) valid[req_idx] <= 1'b1;
  end

  // Tag and data arrays fill on the icache response.
  always_ff @(posedge clk_in) begin
    // NOTE: storage arrays have no reset; the valid bits alone mark contents
    // meaningful, which keeps the arrays mappable to plain RAM.
    if (rdy_in && resp) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= mem_data_in;
    end
  end

`ifdef ICACHE_STAT_EN
  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_out   <= 32'h0;
      miss_cnt_out  <= 32'h0;
      stall_cnt_out <= 32'h0;
    end else if (rdy_in) begin
      if (hit_acc)  hit_cnt_out  <= hit_cnt_out + 32'd1;
      if (miss_acc) miss_cnt_out <= miss_cnt_out + 32'd1;
      if (state == MISS && icache_block_in) stall_cnt_out <= stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed testbench for icache_fetch_unit (default build, INDEX_BITS=6).
module tb_icache_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_in;
  logic        fetch_valid_in;
  logic        flush_in;
  logic        ready_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_r_nw_out;
  logic [2:0]  mem_type_out;
  logic        mem_activate_out;
  logic [31:0] mem_data_in;
  logic        mem_available_in;
  logic [1:0]  mem_task_src_in;
  logic        icache_block_in;

  int total = 0;
  int bad   = 0;

  icache_fetch_unit #(.INDEX_BITS(6)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .pc_in            (pc_in),
    .fetch_valid_in   (fetch_valid_in),
    .flush_in         (flush_in),
    .ready_out        (ready_out),
    .inst_out         (inst_out),
    .inst_valid_out   (inst_valid_out),
    .mem_addr_out     (mem_addr_out),
    .mem_data_out     (mem_data_out),
    .mem_r_nw_out     (mem_r_nw_out),
    .mem_type_out     (mem_type_out),
    .mem_activate_out (mem_activate_out),
    .mem_data_in      (mem_data_in),
    .mem_available_in (mem_available_in),
    .mem_task_src_in  (mem_task_src_in),
    .icache_block_in  (icache_block_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic respond(input logic [1:0] src, input logic [31:0] data);
    mem_available_in = 1'b1;
    mem_task_src_in  = src;
    mem_data_in      = data;
  endtask

  task automatic no_resp();
    mem_available_in = 1'b0;
    mem_task_src_in  = 2'b00;
    mem_data_in      = 32'h0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; pc_in = 32'h0; fetch_valid_in = 1'b0;
    flush_in = 1'b0; icache_block_in = 1'b0;
    no_resp();
    #12;
    check("rst_ready", ready_out, 1);
    check("rst_valid", inst_valid_out, 0);
    check("rst_inst", inst_out, 0);
    check("rst_act", mem_activate_out, 0);
    check("rst_addr", mem_addr_out, 0);
    check("const_rnw", mem_r_nw_out, 1);
    check("const_type", mem_type_out, 0);
    check("const_data", mem_data_out, 0);
    rst_in = 1'b0;
    step();

    // Cold miss at 0x0.
    pc_in = 32'h0; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("cold_act", mem_activate_out, 1);
    check("cold_addr", mem_addr_out, 32'h0);
    check("cold_ready", ready_out, 0);
    check("cold_nvalid", inst_valid_out, 0);
    respond(2'b10, 32'h0000_0093);
    step();
    no_resp();
    check("cold_valid", inst_valid_out, 1);
    check("cold_inst", inst_out, 32'h0000_0093);
    check("cold_act_drop", mem_activate_out, 0);
    check("cold_addr_drop", mem_addr_out, 0);
    check("cold_ready_back", ready_out, 1);

    // Back-to-back hits.
    fetch_valid_in = 1'b1;
    step();
    check("hit1_valid", inst_valid_out, 1);
    check("hit1_inst", inst_out, 32'h0000_0093);
    check("hit1_act", mem_activate_out, 0);
    step();
    fetch_valid_in = 1'b0;
    check("hit2_valid", inst_valid_out, 1);
    check("hit2_ready", ready_out, 1);
    step();
    check("hit_pulse_end", inst_valid_out, 0);

    // Conflict: 0x100 maps onto the same line as 0x0.
    pc_in = 32'h100; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("conf_act", mem_activate_out, 1);
    check("conf_addr", mem_addr_out, 32'h100);
    respond(2'b10, 32'hAAAA_0100);
    step();
    no_resp();
    check("conf_inst", inst_out, 32'hAAAA_0100);
    check("conf_valid", inst_valid_out, 1);
    pc_in = 32'h0; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("refetch_miss", mem_activate_out, 1);
    check("refetch_addr", mem_addr_out, 32'h0);
    check("refetch_nvalid", inst_valid_out, 0);

    // Foreign response and controller block while in MISS.
    respond(2'b01, 32'hDEAD_BEEF); icache_block_in = 1'b1;
    step();
    check("foreign_act", mem_activate_out, 1);
    check("foreign_addr", mem_addr_out, 32'h0);
    check("foreign_nvalid", inst_valid_out, 0);
    check("foreign_ready", ready_out, 0);
    no_resp();
    step();
    check("block_act", mem_activate_out, 1);
    icache_block_in = 1'b0;
    respond(2'b10, 32'h0000_0013);
    step();
    no_resp();
    check("own_valid", inst_valid_out, 1);
    check("own_inst", inst_out, 32'h0000_0013);

    // Flush mid-miss: fill happens, no instruction delivered.
    pc_in = 32'h40; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0; flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("flush_act_held", mem_activate_out, 1);
    check("flush_addr_held", mem_addr_out, 32'h40);
    respond(2'b10, 32'h0000_006F);
    step();
    no_resp();
    check("flush_nvalid", inst_valid_out, 0);
    check("flush_act_drop", mem_activate_out, 0);
    fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("flush_hit_valid", inst_valid_out, 1);
    check("flush_hit_inst", inst_out, 32'h0000_006F);
    check("flush_hit_noact", mem_activate_out, 0);

    // Flush in IDLE cancels a same-cycle hit.
    fetch_valid_in = 1'b1; flush_in = 1'b1;
    step();
    fetch_valid_in = 1'b0; flush_in = 1'b0;
    check("idle_flush_nvalid", inst_valid_out, 0);
    check("idle_flush_noact", mem_activate_out, 0);

    // Flush coincident with the response.
    pc_in = 32'h80; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    flush_in = 1'b1; respond(2'b10, 32'h0000_0077);
    step();
    flush_in = 1'b0; no_resp();
    check("coinc_nvalid", inst_valid_out, 0);
    check("coinc_act", mem_activate_out, 0);
    fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("coinc_hit_inst", inst_out, 32'h0000_0077);
    check("coinc_hit_valid", inst_valid_out, 1);

    // Freeze during MISS: a response while frozen must not be taken.
    pc_in = 32'hC0; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("frz_pre_act", mem_activate_out, 1);
    rdy_in = 1'b0; respond(2'b10, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_act", mem_activate_out, 1);
      check("frz_addr", mem_addr_out, 32'hC0);
      check("frz_nvalid", inst_valid_out, 0);
      check("frz_ready", ready_out, 0);
    end
    rdy_in = 1'b1; no_resp();
    step();
    check("frz_post_act", mem_activate_out, 1);

    // Async reset mid-MISS clears everything without waiting for an edge.
    rst_in = 1'b1;
    #2;
    check("arst_act", mem_activate_out, 0);
    check("arst_addr", mem_addr_out, 0);
    check("arst_ready", ready_out, 1);
    rst_in = 1'b0;
    pc_in = 32'h40; fetch_valid_in = 1'b1;
    step();
    fetch_valid_in = 1'b0;
    check("post_rst_miss", mem_activate_out, 1);
    check("post_rst_addr", mem_addr_out, 32'h40);
    check("post_rst_nvalid", inst_valid_out, 0);
    respond(2'b10, 32'h0000_0055);
    step();
    no_resp();
    check("post_rst_inst", inst_out, 32'h0000_0055);
    check("post_rst_valid", inst_valid_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
